xsw_rsp_return: RTL and testbench

- Response-return path for the N-initiator x M-target crossbar.
- Snoops each accepted forward request per target and records the granted source index in a per-target ID FIFO.
- Routes each target's response back to that source, in request order per target.
- Arbitrates round-robin per initiator when several targets respond to the same initiator in the same cycle. Sits beside the forward switch, on the opposite side of the vld/gnt protocol.

---
 rtl/xsw_pkg.sv | 12 +
 rtl/xarr.sv | 54 +++++
 rtl/xsw_id_fifo.sv | 69 ++++++
 rtl/xsw_rsp_return.sv | 113 +++++++++++
 tb/tb_xsw_rsp_return.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xsw_pkg.sv
// rtl/xsw_pkg.sv - shared constants and helpers for the crossbar response-return path
package xsw_pkg;

  localparam int ERR_OVF    = 0;
  localparam int ERR_ORPHAN = 1;

  // Source-ID width; a single initiator still needs one bit to carry the ID.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xarr.sv
// rtl/xarr.sv - round-robin arbiter; priority moves past the winner only on en
module xarr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] req,
  input  logic         en,
  output logic [W-1:0] gnt
);

  localparam int PW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx, win;
  logic          found;
  int            t;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    win   = '0;
    found = 1'b0;
    t     = 0;
    for (int i = 0; i < W; i++) begin
      t = int'(ptr_q) + i;
      if (t >= W) begin
        t = t - W;
      end
      idx = t[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      gnt[win] = 1'b1;
    end
    // Holding the pointer while the winner waits keeps the grant lock-free.
    if (en && found) begin
      ptr_d = (win == PW'(W - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/xsw_id_fifo.sv
// rtl/xsw_id_fifo.sv - per-target FIFO of granted source IDs, in acceptance order
module xsw_id_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [IW-1:0] din,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          empty,
  output logic          full,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so push+pop is accepted even when full.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/xsw_rsp_return.sv
// rtl/xsw_rsp_return.sv - routes target responses back to the requesting initiator
module xsw_rsp_return
  import xsw_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int M     = 2,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int IW    = id_width(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [M-1:0]    req_fire,
  input  logic [M*IW-1:0] req_src,
  output logic [M-1:0]    full_o,
  input  logic [M-1:0]    rvld_i,
  input  logic [M*DW-1:0] rdat_i,
  output logic [M-1:0]    rgnt_i,
  output logic [N-1:0]    rvld_o,
  output logic [N*DW-1:0] rdat_o,
  input  logic [N-1:0]    rgnt_o,
  output logic [1:0]      err_o
);

  logic [IW-1:0] head [M];
  logic [M-1:0]  empty, full, ovf, pop;
  logic [M-1:0]  cand [N];
  logic [M-1:0]  gnt  [N];
  logic [N-1:0]  xfer;
  logic [1:0]    err_q, err_d;

  for (genvar m = 0; m < M; m++) begin : g_tgt
    assign pop[m] = rvld_i[m] & rgnt_i[m];

    xsw_id_fifo #(
      .DEPTH (DEPTH),
      .IW    (IW)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (req_fire[m]),
      .din   (req_src[m*IW +: IW]),
      .pop   (pop[m]),
      .head  (head[m]),
      .empty (empty[m]),
      .full  (full[m]),
      .ovf   (ovf[m])
    );
  end

  for (genvar n = 0; n < N; n++) begin : g_ini
    // No bypass: a target is routable only once its ID is already registered.
    always_comb begin
      cand[n] = '0;
      for (int m = 0; m < M; m++) begin
        cand[n][m] = rvld_i[m] & ~empty[m] & (head[m] == IW'(n));
      end
    end

    assign rvld_o[n] = |cand[n];
    assign xfer[n]   = rvld_o[n] & rgnt_o[n];

    xarr #(
      .W (M)
    ) u_arb (
      .clk  (clk),
      .rstn (rstn),
      .req  (cand[n]),
      .en   (xfer[n]),
      .gnt  (gnt[n])
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (rstn) begin
        assert ($onehot0(gnt[n]));
      end
    end
`endif
  end

  // A target can only be granted by the initiator its head names, so OR-ing is exact.
  always_comb begin
    rdat_o = '0;
    rgnt_i = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (gnt[n][m]) begin
          rdat_o[n*DW +: DW] = rdat_o[n*DW +: DW] | rdat_i[m*DW +: DW];
          rgnt_i[m]          = rgnt_i[m] | rgnt_o[n];
        end
      end
    end
  end

  always_comb begin
    err_d             = err_q;
    err_d[ERR_OVF]    = err_q[ERR_OVF] | (|ovf);
    err_d[ERR_ORPHAN] = err_q[ERR_ORPHAN] | (|(rvld_i & empty));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign full_o = full;
  assign err_o  = err_q;

endmodule

// File: tb/tb_xsw_rsp_return.sv
// tb/tb_xsw_rsp_return.sv - scoreboard bench for the crossbar response-return path
module tb_xsw_rsp_return;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req_fire, req_src, rvld_i, rgnt_o;
  logic [1:0]  full_o, rgnt_i, rvld_o, err_o;
  logic [15:0] rdat_i, rdat_o;

  typedef struct {
    int         dst;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  xsw_rsp_return #(
    .N     (2),
    .M     (2),
    .DW    (8),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_fire (req_fire),
    .req_src  (req_src),
    .full_o   (full_o),
    .rvld_i   (rvld_i),
    .rdat_i   (rdat_i),
    .rgnt_i   (rgnt_i),
    .rvld_o   (rvld_o),
    .rdat_o   (rdat_o),
    .rgnt_o   (rgnt_o),
    .err_o    (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_fire = '0;
    req_src  = '0;
    rvld_i   = '0;
    rdat_i   = '0;
    rgnt_o   = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic expect_rsp(input int dst, input logic [7:0] d);
    exp_t e;
    e.dst = dst;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // Called mid-cycle: every initiator-side transfer must match the queue head.
  task automatic sb_check();
    exp_t e;
    for (int n = 0; n < 2; n++) begin
      if (rvld_o[n] && rgnt_o[n]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: initiator %0d got %h, none expected", n, rdat_o[n*8 +: 8]);
        end else begin
          e = exp_q.pop_front();
          if (e.dst != n || rdat_o[n*8 +: 8] !== e.dat) begin
            n_bad++;
            $display("FAIL sb_rsp: got init %0d data %h, expected init %0d data %h",
                     n, rdat_o[n*8 +: 8], e.dst, e.dat);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rvld_i = 2'b11; rdat_i = 16'h5A5A; rgnt_o = 2'b11; rstn = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (rvld_o !== 2'b00) begin n_bad++; $display("FAIL rst_rvld_o: got %b expected 00", rvld_o); end
    n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL rst_rgnt_i: got %b expected 00", rgnt_i); end
    n_cmp++; if (full_o !== 2'b00) begin n_bad++; $display("FAIL rst_full_o: got %b expected 00", full_o); end
    n_cmp++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL rst_err_o: got %b expected 00", err_o); end
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();
    n_cmp++; if (err_o !== 2'b10) begin n_bad++; $display("FAIL rst_orphan: got %b expected 10", err_o); end
    n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL rst_orphan_gnt: got %b expected 00", rgnt_i); end
    do_reset();
    n_cmp++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL rst_clear: got %b expected 00", err_o); end
  endtask

  task automatic test_route();
    do_reset();
    req_fire = 2'b01; req_src = 2'b01; tick();
    req_src = 2'b00; tick();
    req_fire = 2'b00;
    rvld_i = 2'b01; rdat_i = 16'h00A1; rgnt_o = 2'b11; expect_rsp(1, 8'hA1);
    @(negedge clk);
    n_cmp++; if (rvld_o !== 2'b10) begin n_bad++; $display("FAIL route_vld1: got %b expected 10", rvld_o); end
    n_cmp++; if (rgnt_i !== 2'b01) begin n_bad++; $display("FAIL route_gnt1: got %b expected 01", rgnt_i); end
    sb_check();
    tick();
    rdat_i = 16'h00A2; expect_rsp(0, 8'hA2);
    @(negedge clk);
    n_cmp++; if (rvld_o !== 2'b01) begin n_bad++; $display("FAIL route_vld2: got %b expected 01", rvld_o); end
    sb_check();
    tick();
    rdat_i = 16'h00A3;
    @(negedge clk);
    n_cmp++; if (rvld_o !== 2'b00) begin n_bad++; $display("FAIL route_empty_vld: got %b expected 00", rvld_o); end
    n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL route_empty_gnt: got %b expected 00", rgnt_i); end
    tick();
    n_cmp++; if (err_o !== 2'b10) begin n_bad++; $display("FAIL route_orphan: got %b expected 10", err_o); end
    idle();
  endtask

  task automatic test_round_robin();
    int i0, i1;
    logic [1:0] eg;
    do_reset();
    req_fire = 2'b11; req_src = 2'b00; tick(); tick();
    req_fire = 2'b00;
    rgnt_o = 2'b01; i0 = 0; i1 = 0;
    expect_rsp(0, 8'hB0); expect_rsp(0, 8'hC0); expect_rsp(0, 8'hB1); expect_rsp(0, 8'hC1);
    for (int c = 0; c < 4; c++) begin
      rdat_i = {8'(8'hC0 + i1), 8'(8'hB0 + i0)};
      rvld_i = {i1 < 2, i0 < 2};
      eg = (c % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_cmp++; if (rgnt_i !== eg) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, rgnt_i, eg); end
      n_cmp++; if (rvld_o[1] !== 1'b0) begin n_bad++; $display("FAIL rr_vld1[%0d]: got %b expected 0", c, rvld_o[1]); end
      sb_check();
      if (rgnt_i[0]) i0++;
      if (rgnt_i[1]) i1++;
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    req_fire = 2'b10; req_src = 2'b10;
    repeat (4) tick();
    req_fire = 2'b00;
    n_cmp++; if (full_o !== 2'b10) begin n_bad++; $display("FAIL full_set: got %b expected 10", full_o); end
    n_cmp++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL full_noerr: got %b expected 00", err_o); end
    req_fire = 2'b10; rvld_i = 2'b10; rdat_i = 16'hE000; rgnt_o = 2'b10; expect_rsp(1, 8'hE0);
    @(negedge clk);
    n_cmp++; if (rgnt_i !== 2'b10) begin n_bad++; $display("FAIL full_pp_gnt: got %b expected 10", rgnt_i); end
    sb_check();
    tick();
    n_cmp++; if (err_o !== 2'b00) begin n_bad++; $display("FAIL full_pp_err: got %b expected 00", err_o); end
    n_cmp++; if (full_o !== 2'b10) begin n_bad++; $display("FAIL full_pp_full: got %b expected 10", full_o); end
    rvld_i = 2'b00;
    tick();
    req_fire = 2'b00;
    n_cmp++; if (err_o !== 2'b01) begin n_bad++; $display("FAIL full_ovf: got %b expected 01", err_o); end
    n_cmp++; if (full_o !== 2'b10) begin n_bad++; $display("FAIL full_ovf_full: got %b expected 10", full_o); end
    rvld_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      rdat_i = {8'(8'hD0 + k), 8'h00};
      expect_rsp(1, 8'(8'hD0 + k));
      @(negedge clk);
      n_cmp++;
      if (full_o !== ((k == 0) ? 2'b10 : 2'b00)) begin
        n_bad++; $display("FAIL drain_full[%0d]: got %b expected %b", k, full_o, (k == 0) ? 2'b10 : 2'b00);
      end
      sb_check();
      tick();
    end
    @(negedge clk);
    n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL drain_empty_gnt: got %b expected 00", rgnt_i); end
    n_cmp++; if (rvld_o !== 2'b00) begin n_bad++; $display("FAIL drain_empty_vld: got %b expected 00", rvld_o); end
    tick();
    n_cmp++; if (err_o !== 2'b11) begin n_bad++; $display("FAIL drain_orphan: got %b expected 11", err_o); end
    idle();
  endtask

  task automatic test_hold();
    do_reset();
    req_fire = 2'b11; req_src = 2'b00; tick();
    req_fire = 2'b00;
    rvld_i = 2'b11; rdat_i = 16'h6655; rgnt_o = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (rvld_o !== 2'b01) begin n_bad++; $display("FAIL hold_vld[%0d]: got %b expected 01", c, rvld_o); end
      n_cmp++; if (rdat_o[7:0] !== 8'h55) begin n_bad++; $display("FAIL hold_dat[%0d]: got %h expected 55", c, rdat_o[7:0]); end
      n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL hold_gnt[%0d]: got %b expected 00", c, rgnt_i); end
      tick();
    end
    rgnt_o = 2'b01; expect_rsp(0, 8'h55);
    @(negedge clk);
    n_cmp++; if (rgnt_i !== 2'b01) begin n_bad++; $display("FAIL hold_win0: got %b expected 01", rgnt_i); end
    sb_check();
    tick();
    rvld_i = 2'b10; expect_rsp(0, 8'h66);
    @(negedge clk);
    n_cmp++; if (rgnt_i !== 2'b10) begin n_bad++; $display("FAIL hold_win1: got %b expected 10", rgnt_i); end
    sb_check();
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_fire = 2'b01; req_src = 2'b00;
    repeat (4) tick();
    req_fire = 2'b00;
    rvld_i = 2'b01; rdat_i = 16'h0077; rgnt_o = 2'b00;
    @(negedge clk);
    n_cmp++; if (full_o !== 2'b01) begin n_bad++; $display("FAIL arst_pre_full: got %b expected 01", full_o); end
    n_cmp++; if (rvld_o !== 2'b01) begin n_bad++; $display("FAIL arst_pre_vld: got %b expected 01", rvld_o); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (full_o !== 2'b00) begin n_bad++; $display("FAIL arst_full: got %b expected 00", full_o); end
    n_cmp++; if (rvld_o !== 2'b00) begin n_bad++; $display("FAIL arst_vld: got %b expected 00", rvld_o); end
    tick();
    rstn = 1'b1; rgnt_o = 2'b11;
    @(negedge clk);
    n_cmp++; if (rgnt_i !== 2'b00) begin n_bad++; $display("FAIL arst_gnt: got %b expected 00", rgnt_i); end
    tick();
    n_cmp++; if (err_o !== 2'b10) begin n_bad++; $display("FAIL arst_orphan: got %b expected 10", err_o); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_route();
    test_round_robin();
    test_full();
    test_hold();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
